// File: rtl/dbg_access_ctrl_if.sv
// Debug bus sharing interface: two burst-read requesters, shared read data,
// and the exclusive debug address/data port toward the DEBUG decoder.
interface dbg_access_ctrl_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          a_req;
  logic [AW-1:0] a_addr;
  logic [LW-1:0] a_len;
  logic          a_gnt;
  logic          a_rvalid;
  logic          a_rready;
  logic          a_done;

  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [LW-1:0] b_len;
  logic          b_gnt;
  logic          b_rvalid;
  logic          b_rready;
  logic          b_done;

  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] chk_addr;
  logic [DW-1:0] chk_data;

  modport slave (
    input  a_req, a_addr, a_len, a_rready,
    input  b_req, b_addr, b_len, b_rready,
    input  chk_data,
    output a_gnt, a_rvalid, a_done,
    output b_gnt, b_rvalid, b_done,
    output rdata, busy, chk_addr
  );

  modport master (
    output a_req, a_addr, a_len, a_rready,
    output b_req, b_addr, b_len, b_rready,
    output chk_data,
    input  a_gnt, a_rvalid, a_done,
    input  b_gnt, b_rvalid, b_done,
    input  rdata, busy, chk_addr
  );
endinterface

// File: rtl/dbg_access_ctrl.sv
// Round-robin arbiter and burst sequencer that owns the debug address bus and
// returns one captured debug word per valid/ready handshake.
module dbg_access_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rstn,
  dbg_access_ctrl_if.slave   bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_RELOAD = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VALID} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1: B holds the bus
  logic          last_q, last_d;     // 1: B was granted last
  logic          rvalid_q, rvalid_d;
  logic          done_q, done_d;
  logic [AW-1:0] chk_addr_q, chk_addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] len_q, len_d;

  logic own_req, own_rdy, pick_b;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      chk_addr_q <= '0;
      rdata_q    <= '0;
      wcnt_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      chk_addr_q <= chk_addr_d;
      rdata_q    <= rdata_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rvalid_d   = rvalid_q;
    done_d     = 1'b0;
    chk_addr_d = chk_addr_q;
    rdata_d    = rdata_q;
    wcnt_d     = wcnt_q;
    len_d      = len_q;
    own_req    = owner_q ? bus.b_req    : bus.a_req;
    own_rdy    = owner_q ? bus.b_rready : bus.a_rready;
    // On a tie the requester that was not served last wins.
    pick_b     = bus.b_req & (~bus.a_req | ~last_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          owner_d    = pick_b;
          last_d     = pick_b;
          chk_addr_d = pick_b ? bus.b_addr : bus.a_addr;
          len_d      = pick_b ? bus.b_len  : bus.a_len;
          wcnt_d     = WAIT_RELOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!own_req) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == '0) begin
          rdata_d  = bus.chk_data;
          rvalid_d = 1'b1;
          state_d  = ST_VALID;
        end else begin
          wcnt_d = wcnt_q - CW'(1);
        end
      end
      ST_VALID: begin
        if (!own_req) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (own_rdy) begin
          rvalid_d = 1'b0;
          if (len_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Only the low half advances so the region select never changes.
            len_d      = len_q - LW'(1);
            chk_addr_d = {chk_addr_q[AW-1:16], chk_addr_q[15:0] + 16'd1};
            wcnt_d     = WAIT_RELOAD;
            state_d    = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.a_gnt    = bus.busy & ~owner_q;
  assign bus.b_gnt    = bus.busy &  owner_q;
  assign bus.a_rvalid = rvalid_q & ~owner_q;
  assign bus.b_rvalid = rvalid_q &  owner_q;
  assign bus.a_done   = done_q   & ~owner_q;
  assign bus.b_done   = done_q   &  owner_q;
  assign bus.rdata    = rdata_q;
  assign bus.chk_addr = chk_addr_q;
endmodule

// File: tb/tb_dbg_access_ctrl.sv
// Scoreboard bench for dbg_access_ctrl: expected words queued at request time,
// compared at each handshake, plus directed latency/arbitration/abort/reset checks.
module tb_dbg_access_ctrl;
  logic clk;
  logic rstn;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   xfer_a, xfer_b, done_a, done_b, last_xfer_cyc;

  typedef struct packed {
    logic        who;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  dbg_access_ctrl_if bus ();

  dbg_access_ctrl #(.RD_LAT(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hCAFE_0000 ^ (a - 32'd4);
  endfunction

  assign bus.chk_data = mem(bus.chk_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic who, input logic [31:0] addr, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = {addr[31:16], addr[15:0] + 16'(i)};
      sb.push_back('{who: who, addr: a, data: mem(a)});
    end
  endtask

  task automatic wait_done(input logic who, input int budget);
    int n;
    n = 0;
    while (!(who ? bus.b_done : bus.a_done) && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(who ? bus.b_done : bus.a_done), 32'd1);
  endtask

  // Transfer monitor: each handshake pops one expected word.
  always @(negedge clk) begin
    exp_t e;
    logic who;
    if (rstn) begin
      if (bus.a_done) done_a <= done_a + 1;
      if (bus.b_done) done_b <= done_b + 1;
      if (bus.a_rvalid || bus.b_rvalid) begin
        chk("excl_rvalid", 32'(bus.a_rvalid & bus.b_rvalid), 32'd0);
        if ((bus.a_rvalid && bus.a_rready) || (bus.b_rvalid && bus.b_rready)) begin
          who = bus.b_rvalid;
          if (who) xfer_b <= xfer_b + 1;
          else     xfer_a <= xfer_a + 1;
          last_xfer_cyc <= cyc;
          if (sb.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("xfer_who",  32'(who), 32'(e.who));
            chk("xfer_addr", bus.chk_addr, e.addr);
            chk("xfer_data", bus.rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, dbase, ngnt, ndone, n;
    logic prev_g, g;
    logic [31:0] r0, ad0;
    n_vec = 0; n_err = 0; cyc = 0;
    xfer_a = 0; xfer_b = 0; done_a = 0; done_b = 0; last_xfer_cyc = 0;
    rstn = 1'b0;
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_len = '0; bus.a_rready = 1'b0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_len = '0; bus.b_rready = 1'b0;
    tick(); tick();
    chk("rst_outs", 32'({bus.a_gnt, bus.a_rvalid, bus.a_done, bus.b_gnt,
                         bus.b_rvalid, bus.b_done, bus.busy}), 32'd0);
    chk("rst_addr", bus.chk_addr, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    tick();

    // Single read latency
    bus.a_addr = 32'h0000_0005; bus.a_len = 8'd0; bus.a_rready = 1'b1; bus.a_req = 1'b1;
    push_burst(1'b0, 32'h0000_0005, 1);
    tick();
    chk("t1_gnt", 32'(bus.a_gnt), 32'd1);
    chk("t1_addr", bus.chk_addr, 32'h0000_0005);
    chk("t1_rvalid_c1", 32'(bus.a_rvalid), 32'd0);
    tick();
    chk("t1_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t1_rdata", bus.rdata, 32'hCAFE_0001);
    tick();
    chk("t1_done", 32'(bus.a_done), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_gnt_off", 32'(bus.a_gnt), 32'd0);
    bus.a_req = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(bus.a_done), 32'd0);

    // Backpressure
    base = xfer_a;
    bus.a_addr = 32'h0000_0100; bus.a_len = 8'd1; bus.a_rready = 1'b0; bus.a_req = 1'b1;
    push_burst(1'b0, 32'h0000_0100, 2);
    n = 0;
    while (!bus.a_rvalid && n < 20) begin tick(); n++; end
    chk("t3_rvalid", 32'(bus.a_rvalid), 32'd1);
    r0 = bus.rdata; ad0 = bus.chk_addr;
    chk("t3_addr0", ad0, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_rdata_stable", bus.rdata, r0);
      chk("t3_addr_stable", bus.chk_addr, ad0);
      chk("t3_rvalid_held", 32'(bus.a_rvalid), 32'd1);
    end
    chk("t3_no_xfer", 32'(xfer_a - base), 32'd0);
    bus.a_rready = 1'b1;
    wait_done(1'b0, 20);
    bus.a_req = 1'b0;
    chk("t3_xfers", 32'(xfer_a - base), 32'd2);
    tick();

    // Burst with 16-bit address wrap
    base = xfer_b; dbase = done_b;
    bus.b_addr = 32'h0004_FFFE; bus.b_len = 8'd3; bus.b_rready = 1'b1; bus.b_req = 1'b1;
    push_burst(1'b1, 32'h0004_FFFE, 4);
    tick();
    chk("t2_gnt", 32'(bus.b_gnt), 32'd1);
    chk("t2_agnt", 32'(bus.a_gnt), 32'd0);
    wait_done(1'b1, 40);
    bus.b_req = 1'b0;
    chk("t2_xfers", 32'(xfer_b - base), 32'd4);
    tick();
    chk("t2_one_done", 32'(done_b - dbase), 32'd1);

    // Tie and round-robin
    bus.a_addr = 32'h10; bus.a_len = 8'd0; bus.b_addr = 32'h20; bus.b_len = 8'd0;
    bus.a_rready = 1'b1; bus.b_rready = 1'b1;
    push_burst(1'b0, 32'h10, 1); push_burst(1'b1, 32'h20, 1);
    push_burst(1'b0, 32'h10, 1); push_burst(1'b1, 32'h20, 1);
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    ngnt = 0; ndone = 0; prev_g = 1'b0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      tick();
      g = bus.a_gnt | bus.b_gnt;
      if (g && !prev_g) begin
        chk("t4_order", 32'(bus.b_gnt), 32'(ngnt % 2));
        if (ngnt > 0) chk("t4_gap", 32'(cyc - last_xfer_cyc), 32'd2);
        ngnt++;
      end
      prev_g = g;
      if (bus.a_done || bus.b_done) ndone++;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("t4_ndone", 32'(ndone), 32'd4);
    tick();

    // Abort with pending requester
    base = xfer_b; dbase = done_b;
    bus.b_addr = 32'h0000_2000; bus.b_len = 8'd7; bus.b_rready = 1'b1; bus.b_req = 1'b1;
    push_burst(1'b1, 32'h0000_2000, 2);
    tick();
    chk("t5_bgnt", 32'(bus.b_gnt), 32'd1);
    bus.a_addr = 32'h0000_3000; bus.a_len = 8'd0; bus.a_req = 1'b1;
    n = 0;
    while ((xfer_b - base) < 2 && n < 30) begin tick(); n++; end
    bus.b_req = 1'b0;
    chk("t5_two_xfers", 32'(xfer_b - base), 32'd2);
    chk("t5_no_preempt", 32'(bus.a_gnt), 32'd0);
    tick();
    chk("t5_bgnt_off", 32'(bus.b_gnt), 32'd0);
    chk("t5_busy_off", 32'(bus.busy), 32'd0);
    chk("t5_no_bdone", 32'(bus.b_done), 32'd0);
    push_burst(1'b0, 32'h0000_3000, 1);
    tick();
    chk("t5_agnt", 32'(bus.a_gnt), 32'd1);
    chk("t5_aaddr", bus.chk_addr, 32'h0000_3000);
    wait_done(1'b0, 20);
    bus.a_req = 1'b0;
    chk("t5_bdone_cnt", 32'(done_b - dbase), 32'd0);
    tick();

    // Reset mid-burst, then tie goes to A
    bus.a_addr = 32'h0000_0400; bus.a_len = 8'd3; bus.a_rready = 1'b0; bus.a_req = 1'b1;
    n = 0;
    while (!bus.a_rvalid && n < 20) begin tick(); n++; end
    chk("t6_in_valid", 32'(bus.a_rvalid), 32'd1);
    rstn = 1'b0;
    bus.a_addr = 32'h0000_0500; bus.a_len = 8'd0; bus.a_rready = 1'b1;
    bus.b_addr = 32'h0000_0600; bus.b_len = 8'd0; bus.b_rready = 1'b1; bus.b_req = 1'b1;
    tick();
    chk("t6_rst_outs", 32'({bus.a_gnt, bus.a_rvalid, bus.a_done, bus.b_gnt,
                            bus.b_rvalid, bus.b_done, bus.busy}), 32'd0);
    chk("t6_rst_addr", bus.chk_addr, 32'd0);
    chk("t6_rst_rdata", bus.rdata, 32'd0);
    rstn = 1'b1;
    push_burst(1'b0, 32'h0000_0500, 1);
    tick();
    chk("t6_agnt", 32'(bus.a_gnt), 32'd1);
    chk("t6_bgnt", 32'(bus.b_gnt), 32'd0);
    wait_done(1'b0, 20);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
